// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result bundle between the EX stage and the multiply/divide unit
interface mdu_iter_if #(
  parameter int W = 32
) ();
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cancel;
  logic [1:0]   hilo_wr;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, a, b, cancel, hilo_wr,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, cancel, hilo_wr,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative multiply/divide unit with private HI/LO registers
module mdu_iter #(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic       clk,
  input  logic       reset,
  mdu_iter_if.slave  bus
);

  localparam int CMAX = (MUL_CYCLES > W + 1) ? MUL_CYCLES : W + 1;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d, b_q, b_d;
  logic [W-1:0]   rem_q, rem_d, quo_q, quo_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic           busy_q, busy_d, done_q, done_d;

  // Multiply datapath: operands widened to 2W so the truncated product is exact modulo 2^(2W).
  logic           op_signed;
  logic [2*W-1:0] a_ext, b_ext, prod, mul_res;

  assign op_signed = ~op_q[0];
  assign a_ext     = op_signed ? {{W{a_q[W-1]}}, a_q} : {{W{1'b0}}, a_q};
  assign b_ext     = op_signed ? {{W{b_q[W-1]}}, b_q} : {{W{1'b0}}, b_q};
  assign prod      = a_ext * b_ext;
  assign mul_res   = !op_q[2] ? prod : (op_q[1] ? acc_q - prod : acc_q + prod);

  // Divide datapath: restoring step on magnitudes; quo_q starts as |a| and shifts quotient bits in.
  logic         a_neg, b_neg, ge;
  logic [W-1:0] b_mag, rem_sub, rem_next, quo_next, q_fix, r_fix;
  logic [W:0]   rem_sh;

  assign a_neg    = op_signed & a_q[W-1];
  assign b_neg    = op_signed & b_q[W-1];
  assign b_mag    = b_neg ? W'(0) - b_q : b_q;
  assign rem_sh   = {rem_q, quo_q[W-1]};
  assign ge       = rem_sh >= {1'b0, b_mag};
  assign rem_sub  = rem_sh[W-1:0] - b_mag;
  assign rem_next = ge ? rem_sub : rem_sh[W-1:0];
  assign quo_next = {quo_q[W-2:0], ge};
  assign q_fix    = (b_q == '0) ? '0 : ((a_neg ^ b_neg) ? W'(0) - quo_q : quo_q);
  assign r_fix    = (b_q == '0) ? '0 : (a_neg ? W'(0) - rem_q : rem_q);

  logic         start_div, start_signed;
  logic [W-1:0] a_mag_in;

  assign start_div    = (bus.op[2:1] == 2'b01);
  assign start_signed = ~bus.op[0];
  assign a_mag_in     = (start_signed & bus.a[W-1]) ? W'(0) - bus.a : bus.a;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      if (bus.cancel) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end else if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (state_q == S_MUL) begin
          {hi_d, lo_d} = mul_res;
        end else begin
          hi_d = r_fix;
          lo_d = q_fix;
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
        if (state_q == S_DIV) begin
          rem_d = rem_next;
          quo_d = quo_next;
        end
      end
    end else if (!bus.cancel) begin
      // Only a real MTHI/MTLO code wins over start; 11 counts as no write.
      if (bus.hilo_wr == 2'b01) begin
        hi_d = bus.a;
      end else if (bus.hilo_wr == 2'b10) begin
        lo_d = bus.a;
      end else if (bus.start) begin
        op_d    = bus.op;
        a_d     = bus.a;
        b_d     = bus.b;
        acc_d   = {hi_q, lo_q};
        rem_d   = '0;
        quo_d   = a_mag_in;
        busy_d  = 1'b1;
        state_d = start_div ? S_DIV : S_MUL;
        cnt_d   = start_div ? CW'(W + 1) : CW'(MUL_CYCLES);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// tb/tb_mdu_iter.sv - directed self-checking bench for mdu_iter at W=32/5 cycles and W=16/1 cycle
module tb_mdu_iter;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mdu_iter_if #(.W(32)) bus32 ();
  mdu_iter_if #(.W(16)) bus16 ();

  mdu_iter #(.W(32), .MUL_CYCLES(5)) dut32 (.clk(clk), .reset(reset), .bus(bus32.slave));
  mdu_iter #(.W(16), .MUL_CYCLES(1)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hilo_write(input logic [1:0] sel, input logic [31:0] v);
    bus32.hilo_wr = sel;
    bus32.a       = v;
    tick();
    bus32.hilo_wr = 2'b00;
  endtask

  // Issues one op on the 32-bit unit, counts busy cycles and done pulses seen afterwards.
  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cyc, output int dn);
    bus32.op = op; bus32.a = a; bus32.b = b; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    cyc = 0;
    while (bus32.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    dn = int'(bus32.done);
    repeat (3) begin
      tick();
      dn += int'(bus32.done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    n_tests++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", bus32.busy); end
    n_tests++; if (bus32.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", bus32.done); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0) begin n_fail++; $display("FAIL reset_hilo: got %h want 0", {bus32.hi, bus32.lo}); end
    n_tests++; if ({bus16.busy, bus16.hi, bus16.lo} !== 33'h0) begin n_fail++; $display("FAIL reset_w16: got %h want 0", {bus16.busy, bus16.hi, bus16.lo}); end
  endtask

  task automatic test_mult();
    int cyc, dn;
    run32(3'd0, 32'hFFFF_FFFE, 32'd3, cyc, dn);
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL mult_latency: got %0d want 5", cyc); end
    n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL mult_done: got %0d pulses want 1", dn); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL mult_result: got %h want ffffffff_fffffffa", {bus32.hi, bus32.lo}); end
    run32(3'd1, 32'hFFFF_FFFE, 32'd3, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0002_FFFF_FFFA) begin n_fail++; $display("FAIL multu_result: got %h want 00000002_fffffffa", {bus32.hi, bus32.lo}); end
  endtask

  task automatic test_macc();
    int cyc, dn;
    hilo_write(2'b01, 32'd0);
    hilo_write(2'b10, 32'd10);
    run32(3'd6, 32'd4, 32'd3, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_fail++; $display("FAIL msub_result: got %h want ffffffff_fffffffe", {bus32.hi, bus32.lo}); end
    hilo_write(2'b01, 32'd0);
    hilo_write(2'b10, 32'hFFFF_FFFF);
    run32(3'd5, 32'd1, 32'd1, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL maddu_result: got %h want 00000001_00000000", {bus32.hi, bus32.lo}); end
    run32(3'd4, 32'hFFFF_FFFF, 32'd2, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0000_FFFF_FFFE) begin n_fail++; $display("FAIL madd_result: got %h want 00000000_fffffffe", {bus32.hi, bus32.lo}); end
  endtask

  task automatic test_div();
    int cyc, dn;
    run32(3'd2, 32'hFFFF_FFF9, 32'd2, cyc, dn);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div_latency: got %0d want 33", cyc); end
    n_tests++; if (dn !== 1) begin n_fail++; $display("FAIL div_done: got %0d pulses want 1", dn); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg_a: got %h want ffffffff_fffffffd", {bus32.hi, bus32.lo}); end
    run32(3'd2, 32'd7, 32'hFFFF_FFFE, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0001_FFFF_FFFD) begin n_fail++; $display("FAIL div_neg_b: got %h want 00000001_fffffffd", {bus32.hi, bus32.lo}); end
    run32(3'd3, 32'd100, 32'd7, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0002_0000_000E) begin n_fail++; $display("FAIL divu_result: got %h want 00000002_0000000e", {bus32.hi, bus32.lo}); end
    run32(3'd3, 32'd7, 32'd0, cyc, dn);
    n_tests++; if (cyc !== 33) begin n_fail++; $display("FAIL div0_latency: got %0d want 33", cyc); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0) begin n_fail++; $display("FAIL div0_result: got %h want 0", {bus32.hi, bus32.lo}); end
    run32(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, cyc, dn);
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_0000_8000_0000) begin n_fail++; $display("FAIL div_min_m1: got %h want 00000000_80000000", {bus32.hi, bus32.lo}); end
  endtask

  task automatic test_cancel();
    int dn;
    hilo_write(2'b01, 32'h1234);
    hilo_write(2'b10, 32'h5678);
    bus32.op = 3'd2; bus32.a = 32'd100; bus32.b = 32'd7; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    repeat (9) tick();
    n_tests++; if (bus32.busy !== 1'b1) begin n_fail++; $display("FAIL cancel_busy_before: got %0b want 1", bus32.busy); end
    bus32.cancel = 1'b1;
    tick();
    bus32.cancel = 1'b0;
    n_tests++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy_after: got %0b want 0", bus32.busy); end
    dn = 0;
    repeat (40) begin
      dn += int'(bus32.done);
      tick();
    end
    n_tests++; if (dn !== 0) begin n_fail++; $display("FAIL cancel_no_done: got %0d pulses want 0", dn); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h0000_1234_0000_5678) begin n_fail++; $display("FAIL cancel_hilo: got %h want 00001234_00005678", {bus32.hi, bus32.lo}); end
  endtask

  task automatic test_priority();
    int cyc;
    bus32.op = 3'd0; bus32.a = 32'd2; bus32.b = 32'd3; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    tick();
    bus32.op = 3'd3; bus32.a = 32'd100; bus32.b = 32'd7; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    cyc = 2;
    while (bus32.busy && cyc < 100) begin
      cyc++;
      tick();
    end
    n_tests++; if (cyc !== 5) begin n_fail++; $display("FAIL busy_start_latency: got %0d want 5", cyc); end
    n_tests++; if ({bus32.hi, bus32.lo} !== 64'h6) begin n_fail++; $display("FAIL busy_start_result: got %h want 6", {bus32.hi, bus32.lo}); end
    tick();
    n_tests++; if (bus32.busy !== 1'b0) begin n_fail++; $display("FAIL busy_start_queued: got %0b want 0", bus32.busy); end
    bus32.hilo_wr = 2'b10; bus32.a = 32'd5; bus32.b = 32'd3; bus32.op = 3'd0; bus32.start = 1'b1;
    tick();
    bus32.hilo_wr = 2'b00; bus32.start = 1'b0;
    n_tests++; if (bus32.lo !== 32'd5 || bus32.busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_vs_start: got lo=%h busy=%0b want lo=5 busy=0", bus32.lo, bus32.busy); end
    bus32.cancel = 1'b1; bus32.hilo_wr = 2'b10; bus32.a = 32'd9; bus32.start = 1'b1;
    tick();
    bus32.cancel = 1'b0; bus32.hilo_wr = 2'b00; bus32.start = 1'b0;
    n_tests++; if (bus32.lo !== 32'd5 || bus32.busy !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: got lo=%h busy=%0b want lo=5 busy=0", bus32.lo, bus32.busy); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bus32.op = 3'd1; bus32.a = 32'd2; bus32.b = 32'd3; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    cyc = 0;
    while (bus32.busy && cyc < 100) begin cyc++; tick(); end
    n_tests++; if (bus32.lo !== 32'd6 || bus32.done !== 1'b1) begin n_fail++; $display("FAIL b2b_first: got lo=%h done=%0b want lo=6 done=1", bus32.lo, bus32.done); end
    bus32.a = 32'd4; bus32.b = 32'd5; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    n_tests++; if (bus32.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got busy=%0b want 1", bus32.busy); end
    cyc = 0;
    while (bus32.busy && cyc < 100) begin cyc++; tick(); end
    n_tests++; if (cyc !== 5 || bus32.lo !== 32'd20) begin n_fail++; $display("FAIL b2b_second: got cyc=%0d lo=%h want cyc=5 lo=14", cyc, bus32.lo); end
  endtask

  task automatic test_reset_mid();
    hilo_write(2'b01, 32'hAAAA);
    bus32.op = 3'd0; bus32.a = 32'd7; bus32.b = 32'd9; bus32.start = 1'b1;
    tick();
    bus32.start = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests++; if ({bus32.busy, bus32.done, bus32.hi, bus32.lo} !== 66'h0) begin n_fail++; $display("FAIL reset_mid: got busy=%0b done=%0b hi=%h lo=%h want all 0", bus32.busy, bus32.done, bus32.hi, bus32.lo); end
    repeat (6) tick();
    n_tests++; if ({bus32.done, bus32.hi, bus32.lo} !== 65'h0) begin n_fail++; $display("FAIL reset_mid_later: got done=%0b hi=%h lo=%h want all 0", bus32.done, bus32.hi, bus32.lo); end
  endtask

  task automatic test_w16();
    int cyc;
    bus16.op = 3'd0; bus16.a = 16'hFFFE; bus16.b = 16'd3; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    cyc = 0;
    while (bus16.busy && cyc < 100) begin cyc++; tick(); end
    n_tests++; if (cyc !== 1) begin n_fail++; $display("FAIL w16_mult_latency: got %0d want 1", cyc); end
    n_tests++; if ({bus16.hi, bus16.lo, bus16.done} !== {16'hFFFF, 16'hFFFA, 1'b1}) begin n_fail++; $display("FAIL w16_mult: got hi=%h lo=%h done=%0b want ffff fffa 1", bus16.hi, bus16.lo, bus16.done); end
    bus16.op = 3'd2; bus16.a = 16'hFFF9; bus16.b = 16'd2; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    cyc = 0;
    while (bus16.busy && cyc < 100) begin cyc++; tick(); end
    n_tests++; if (cyc !== 17) begin n_fail++; $display("FAIL w16_div_latency: got %0d want 17", cyc); end
    n_tests++; if ({bus16.hi, bus16.lo} !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL w16_div: got %h want ffff_fffd", {bus16.hi, bus16.lo}); end
  endtask

  initial begin
    reset = 1'b1;
    bus32.start = 1'b0; bus32.op = '0; bus32.a = '0; bus32.b = '0; bus32.cancel = 1'b0; bus32.hilo_wr = '0;
    bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0; bus16.cancel = 1'b0; bus16.hilo_wr = '0;
    test_reset();
    test_mult();
    test_macc();
    test_div();
    test_cancel();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_w16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
